// File: rtl/frac_me_sad_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frac_me_pkg: shared definitions for the fractional-pel ME SAD sequencer.
//   - state_t       : sequencer FSM encoding
//   - NUM_CAND      : number of quarter-pel candidates (5x5)
//   - CENTER_IDX    : candidate index of vector (0,0)
//   - ROWS_PER_BLK  : rows per 8x8 block
//   - idx_to_mv()   : candidate index n -> signed (dx, dy), n = 5*(dy+2) + (dx+2)
// -----------------------------------------------------------------------------
package frac_me_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StAccum,
        StCmp,
        StDone
    } state_t;

    localparam int unsigned NUM_CAND     = 25;
    localparam int unsigned CENTER_IDX   = 12;
    localparam int unsigned ROWS_PER_BLK = 8;

    typedef struct packed {
        logic [2:0] dx;
        logic [2:0] dy;
    } mv_t;

    // Two's-complement 3-bit offsets in the range -2..+2.
    function automatic mv_t idx_to_mv(input logic [4:0] idx);
        mv_t        mv;
        logic [2:0] row;
        logic [2:0] col;
        row   = 3'(idx / 5'd5);
        col   = 3'(idx % 5'd5);
        mv.dy = row - 3'd2;
        mv.dx = col - 3'd2;
        return mv;
    endfunction

endpackage

// File: rtl/frac_me_sad_sequencer_compute_sad.sv
// -----------------------------------------------------------------------------
// compute_sad: combinational quarter-pel SAD of one middle row.
// Builds five vertically interpolated rows (U-half, U-quarter, M, L-quarter,
// L-half) from a 3-row window, then five horizontal phases per row, and sums
// |interp - org| over inner pixels 1..6.
// Ports:
//   i_win_u/i_win_m/i_win_l : window rows, 8 px each, pixel 0 in [7:0]
//   i_org                   : original inner pixels 1..6 of the middle row
//   o_sad_uh..o_sad_lh      : dy = -2..+2; field k at [12k+11:12k] is dx = k-2
// -----------------------------------------------------------------------------
module compute_sad #(
    parameter int unsigned ROW_SAD_W = 12
) (
    input  logic [63:0]              i_win_u,
    input  logic [63:0]              i_win_m,
    input  logic [63:0]              i_win_l,
    input  logic [47:0]              i_org,
    output logic [5*ROW_SAD_W-1:0]   o_sad_uh,
    output logic [5*ROW_SAD_W-1:0]   o_sad_uq,
    output logic [5*ROW_SAD_W-1:0]   o_sad_m,
    output logic [5*ROW_SAD_W-1:0]   o_sad_lq,
    output logic [5*ROW_SAD_W-1:0]   o_sad_lh
);

    // Rounded half-sample: (a + b + 1) >> 1
    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    // Rounded quarter-sample weighted toward b: (a + 3b + 2) >> 2
    function automatic logic [7:0] avg13(input logic [7:0] a, input logic [7:0] b);
        logic [9:0] s;
        s = {2'b00, a} + ({2'b00, b} * 10'd3) + 10'd2;
        return s[9:2];
    endfunction

    function automatic logic [7:0] interp_h(input int unsigned k, input logic [7:0] pl,
                                            input logic [7:0] pc, input logic [7:0] pr);
        logic [7:0] p;
        case (k)
            0:       p = avg2(pl, pc);
            1:       p = avg13(pl, pc);
            2:       p = pc;
            3:       p = avg13(pr, pc);
            default: p = avg2(pc, pr);
        endcase
        return p;
    endfunction

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [7:0]           w_v   [5][8];
    logic [ROW_SAD_W-1:0] w_sad [5][5];

    always_comb begin
        w_v = '{default: '0};
        for (int x = 0; x < 8; x++) begin
            w_v[0][x] = avg2(i_win_u[8*x +: 8], i_win_m[8*x +: 8]);
            w_v[1][x] = avg13(i_win_u[8*x +: 8], i_win_m[8*x +: 8]);
            w_v[2][x] = i_win_m[8*x +: 8];
            w_v[3][x] = avg13(i_win_l[8*x +: 8], i_win_m[8*x +: 8]);
            w_v[4][x] = avg2(i_win_m[8*x +: 8], i_win_l[8*x +: 8]);
        end
    end

    always_comb begin
        w_sad = '{default: '0};
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                for (int x = 1; x < 7; x++) begin
                    w_sad[r][k] = w_sad[r][k] + ROW_SAD_W'(absdiff(
                        interp_h(k, w_v[r][x-1], w_v[r][x], w_v[r][x+1]),
                        i_org[8*(x-1) +: 8]));
                end
            end
        end
    end

    always_comb begin
        o_sad_uh = '0;
        o_sad_uq = '0;
        o_sad_m  = '0;
        o_sad_lq = '0;
        o_sad_lh = '0;
        for (int k = 0; k < 5; k++) begin
            o_sad_uh[ROW_SAD_W*k +: ROW_SAD_W] = w_sad[0][k];
            o_sad_uq[ROW_SAD_W*k +: ROW_SAD_W] = w_sad[1][k];
            o_sad_m [ROW_SAD_W*k +: ROW_SAD_W] = w_sad[2][k];
            o_sad_lq[ROW_SAD_W*k +: ROW_SAD_W] = w_sad[3][k];
            o_sad_lh[ROW_SAD_W*k +: ROW_SAD_W] = w_sad[4][k];
        end
    end

endmodule

// File: rtl/frac_me_sad_sequencer.sv
// -----------------------------------------------------------------------------
// frac_me_sad_sequencer: fractional-pel motion-estimation controller.
// Streams one 8x8 reference block plus its original rows, keeps a 3-row window
// feeding compute_sad, accumulates 25 candidate SADs over inner rows 1..6, then
// serially picks the minimum (ties -> center, then lowest index).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start                      : begin a block (only honoured when idle)
//   row_valid/row_ready        : row stream handshake
//   cur_row[63:0]              : reference row, pixel 0 in [7:0]
//   org_row[47:0]              : original inner pixels 1..6 of the same row
//   result_valid/result_ready  : result handshake
//   best_dx, best_dy           : signed quarter-pel vector, -2..+2
//   best_sad                   : SAD of the winning vector
//   sad_all                    : all 25 accumulators (only with FRAC_ME_SAD_DUMP_EN)
// Optional build macro: FRAC_ME_SAD_DUMP_EN adds the sad_all debug output.
// -----------------------------------------------------------------------------
module frac_me_sad_sequencer
    import frac_me_pkg::*;
#(
    parameter int unsigned ACC_W     = 14,
    parameter int unsigned ROW_SAD_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                row_valid,
    output logic                row_ready,
    input  logic [63:0]         cur_row,
    input  logic [47:0]         org_row,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [2:0]          best_dx,
    output logic [2:0]          best_dy,
    output logic [ACC_W-1:0]    best_sad
`ifdef FRAC_ME_SAD_DUMP_EN
    ,
    output logic [NUM_CAND*ACC_W-1:0] sad_all
`endif
);

    localparam int unsigned SUM_W = ((ACC_W > ROW_SAD_W) ? ACC_W : ROW_SAD_W) + 1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_row_cnt;
    logic [63:0]            r_win_u;
    logic [63:0]            r_win_m;
    logic [63:0]            r_win_l;
    logic [47:0]            r_org_s1;
    logic [47:0]            r_org_s2;
    logic                   r_acc_en;
    logic [ACC_W-1:0]       r_acc      [NUM_CAND];
    logic [ACC_W-1:0]       w_acc_next [NUM_CAND];
    logic [ROW_SAD_W-1:0]   w_field    [NUM_CAND];
    logic [4:0]             r_cmp_idx;
    logic [ACC_W-1:0]       r_min_sad;
    logic [2:0]             r_best_dx;
    logic [2:0]             r_best_dy;

    logic                   w_accept;
    logic                   w_first;
    logic                   w_take;
    logic [ACC_W-1:0]       w_cand_sad;
    logic [ACC_W-1:0]       w_base_sad;
    mv_t                    w_cand_mv;
    mv_t                    w_base_mv;

    logic [5*ROW_SAD_W-1:0] w_sad_uh;
    logic [5*ROW_SAD_W-1:0] w_sad_uq;
    logic [5*ROW_SAD_W-1:0] w_sad_m;
    logic [5*ROW_SAD_W-1:0] w_sad_lq;
    logic [5*ROW_SAD_W-1:0] w_sad_lh;

    // Middle row of the window always lines up with r_org_s2.
    compute_sad #(
        .ROW_SAD_W (ROW_SAD_W)
    ) u_compute_sad (
        .i_win_u  (r_win_u),
        .i_win_m  (r_win_m),
        .i_win_l  (r_win_l),
        .i_org    (r_org_s2),
        .o_sad_uh (w_sad_uh),
        .o_sad_uq (w_sad_uq),
        .o_sad_m  (w_sad_m),
        .o_sad_lq (w_sad_lq),
        .o_sad_lh (w_sad_lh)
    );

    assign w_accept = row_valid & row_ready;

    // Flatten the five buses into candidate order n = 5*(dy+2) + (dx+2).
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_field[k]      = w_sad_uh[ROW_SAD_W*k +: ROW_SAD_W];
            w_field[5 + k]  = w_sad_uq[ROW_SAD_W*k +: ROW_SAD_W];
            w_field[10 + k] = w_sad_m [ROW_SAD_W*k +: ROW_SAD_W];
            w_field[15 + k] = w_sad_lq[ROW_SAD_W*k +: ROW_SAD_W];
            w_field[20 + k] = w_sad_lh[ROW_SAD_W*k +: ROW_SAD_W];
        end
    end

    // Saturating accumulate; only reachable when ACC_W is narrowed.
    always_comb begin
        logic [SUM_W-1:0] sum;
        for (int n = 0; n < NUM_CAND; n++) begin
            sum = SUM_W'(r_acc[n]) + SUM_W'(w_field[n]);
            if (|sum[SUM_W-1:ACC_W]) begin
                w_acc_next[n] = '1;
            end else begin
                w_acc_next[n] = sum[ACC_W-1:0];
            end
        end
    end

    // Serial comparator: index 0 compares against the center as the seed.
    always_comb begin
        w_first    = (r_cmp_idx == 5'd0);
        w_cand_sad = r_acc[r_cmp_idx];
        w_cand_mv  = idx_to_mv(r_cmp_idx);
        w_base_sad = w_first ? r_acc[CENTER_IDX] : r_min_sad;
        w_base_mv  = w_first ? '0 : mv_t'{dx: r_best_dx, dy: r_best_dy};
        w_take     = (w_cand_sad < w_base_sad);
    end

    always_comb begin
        w_state_next = r_state;
        row_ready    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StFill;
                end
            end
            StFill: begin
                row_ready = 1'b1;
                if (w_accept && (r_row_cnt == 4'd1)) begin
                    w_state_next = StAccum;
                end
            end
            StAccum: begin
                // Once all rows are in, hold one cycle for the last accumulate.
                row_ready = (r_row_cnt != 4'(ROWS_PER_BLK));
                if (r_row_cnt == 4'(ROWS_PER_BLK)) begin
                    w_state_next = StCmp;
                end
            end
            StCmp: begin
                if (r_cmp_idx == 5'(NUM_CAND - 1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (result_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_row_cnt <= '0;
            r_win_u   <= '0;
            r_win_m   <= '0;
            r_win_l   <= '0;
            r_org_s1  <= '0;
            r_org_s2  <= '0;
            r_acc_en  <= 1'b0;
            r_cmp_idx <= '0;
            r_min_sad <= '0;
            r_best_dx <= '0;
            r_best_dy <= '0;
            for (int n = 0; n < NUM_CAND; n++) begin
                r_acc[n] <= '0;
            end
        end else begin
            r_state  <= w_state_next;
            r_acc_en <= w_accept && (r_state == StAccum);

            if (w_accept) begin
                r_win_u   <= r_win_m;
                r_win_m   <= r_win_l;
                r_win_l   <= cur_row;
                r_org_s1  <= org_row;
                r_org_s2  <= r_org_s1;
                r_row_cnt <= r_row_cnt + 4'd1;
            end

            if ((r_state == StIdle) && start) begin
                r_row_cnt <= '0;
                for (int n = 0; n < NUM_CAND; n++) begin
                    r_acc[n] <= '0;
                end
            end else if (r_acc_en) begin
                for (int n = 0; n < NUM_CAND; n++) begin
                    r_acc[n] <= w_acc_next[n];
                end
            end

            if (r_state == StCmp) begin
                r_cmp_idx <= (r_cmp_idx == 5'(NUM_CAND - 1)) ? 5'd0 : r_cmp_idx + 5'd1;
                r_min_sad <= w_take ? w_cand_sad   : w_base_sad;
                r_best_dx <= w_take ? w_cand_mv.dx : w_base_mv.dx;
                r_best_dy <= w_take ? w_cand_mv.dy : w_base_mv.dy;
            end
        end
    end

    assign result_valid = (r_state == StDone);
    assign best_dx      = r_best_dx;
    assign best_dy      = r_best_dy;
    assign best_sad     = r_min_sad;

`ifdef FRAC_ME_SAD_DUMP_EN
    always_comb begin
        sad_all = '0;
        for (int n = 0; n < NUM_CAND; n++) begin
            sad_all[n*ACC_W +: ACC_W] = r_acc[n];
        end
    end
`endif

endmodule
